// File: rtl/core_pkg.sv
// core_pkg: shared defaults and the write-back entry type for the register file write path
package core_pkg;

   localparam int DefaultDataWidth = 16;
   localparam int DefaultNumRegs   = 16;
   localparam int DefaultAddrWidth = $clog2(DefaultNumRegs);

   typedef struct packed {
      logic [DefaultAddrWidth-1:0] addr;
      logic [DefaultDataWidth-1:0] data;
   } wb_entry_t;

   function automatic wb_entry_t make_entry(input logic [DefaultAddrWidth-1:0] addr,
                                            input logic [DefaultDataWidth-1:0] data);
      make_entry.addr = addr;
      make_entry.data = data;
   endfunction

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: small synchronous queue of write-back entries with flush
module wb_fifo import core_pkg::*; #(
   parameter  int Depth      = 4,
   localparam int PtrWidth   = $clog2(Depth),
   localparam int CountWidth = $clog2(Depth + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  push,
   input  logic                  pop,
   input  logic                  flush,
   input  wb_entry_t             din,
   output wb_entry_t             dout,
   output logic [CountWidth-1:0] count
);

   wb_entry_t             mem_q [Depth];
   wb_entry_t             mem_d [Depth];
   logic [PtrWidth-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PtrWidth-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CountWidth-1:0] count_q, count_d;

   // next pointers, occupancy and storage; flush discards everything queued
   always_comb begin
      mem_d = mem_q;
      if (push && !flush) mem_d[wr_ptr_q] = din;
      wr_ptr_d = flush ? '0 : wr_ptr_q + PtrWidth'(push);
      rd_ptr_d = flush ? '0 : rd_ptr_q + PtrWidth'(pop);
      count_d  = flush ? '0 : count_q + CountWidth'(push) - CountWidth'(pop);
   end

   // pointer and occupancy registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // entry storage needs no reset; occupancy alone decides what is valid
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign dout  = mem_q[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/regfile_writeback.sv
// regfile_writeback: arbitrates ALU/LSU results into a queue, drains one register write per cycle, tracks pending destinations
module regfile_writeback import core_pkg::*; #(
   parameter  int DataWidth  = DefaultDataWidth,
   parameter  int NumRegs    = DefaultNumRegs,
   parameter  int FifoDepth  = 4,
   localparam int AddrWidth  = $clog2(NumRegs),
   localparam int CountWidth = $clog2(FifoDepth + 1)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 alu_valid,
   output logic                 alu_ready,
   input  logic [AddrWidth-1:0] alu_addr,
   input  logic [DataWidth-1:0] alu_data,
   input  logic                 lsu_valid,
   output logic                 lsu_ready,
   input  logic [AddrWidth-1:0] lsu_addr,
   input  logic [DataWidth-1:0] lsu_data,
   input  logic                 claim_en,
   input  logic [AddrWidth-1:0] claim_addr,
   input  logic                 flush,
   output logic [NumRegs-1:0]   pending,
   output logic                 reg_w_en,
   output logic [AddrWidth-1:0] addr_in,
   output logic [DataWidth-1:0] reg_in
);

   logic [CountWidth-1:0] count;
   logic                  lsu_fire, alu_fire, push, pop;
   wb_entry_t             push_entry, head_entry;
   logic                  reg_w_en_q, reg_w_en_d;
   logic [AddrWidth-1:0]  addr_in_q, addr_in_d;
   logic [DataWidth-1:0]  reg_in_q, reg_in_d;
   logic [NumRegs-1:0]    pending_q, pending_d;
   logic [NumRegs-1:0]    set_mask, clr_mask;

   // arbitration: LSU wins, ALU only gets a slot when the LSU is idle; queue always drains unless flushed
   always_comb begin
      lsu_ready  = rst_n && (count < CountWidth'(FifoDepth)) && !flush;
      alu_ready  = lsu_ready && !lsu_valid;
      lsu_fire   = lsu_valid && lsu_ready;
      alu_fire   = alu_valid && alu_ready;
      push       = lsu_fire || alu_fire;
      push_entry = lsu_fire ? make_entry(lsu_addr, lsu_data) : make_entry(alu_addr, alu_data);
      pop        = (count != '0) && !flush;
   end

   wb_fifo #(.Depth(FifoDepth)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .flush (flush),
      .din   (push_entry),
      .dout  (head_entry),
      .count (count)
   );

   // output register: a popped head becomes next cycle's write; address and data hold when idle
   always_comb begin
      reg_w_en_d = pop;
      addr_in_d  = pop ? head_entry.addr : addr_in_q;
      reg_in_d   = pop ? head_entry.data : reg_in_q;
   end

   // scoreboard: claims set, completed writes clear, a same-edge claim beats the clear
   always_comb begin
      set_mask  = (claim_en && !flush) ? (NumRegs'(1) << claim_addr) : '0;
      clr_mask  = reg_w_en_q ? (NumRegs'(1) << addr_in_q) : '0;
      pending_d = flush ? '0 : ((pending_q & ~clr_mask) | set_mask);
   end

   // output and scoreboard registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         reg_w_en_q <= 1'b0;
         addr_in_q  <= '0;
         reg_in_q   <= '0;
         pending_q  <= '0;
      end else begin
         reg_w_en_q <= reg_w_en_d;
         addr_in_q  <= addr_in_d;
         reg_in_q   <= reg_in_d;
         pending_q  <= pending_d;
      end
   end

   assign reg_w_en = reg_w_en_q;
   assign addr_in  = addr_in_q;
   assign reg_in   = reg_in_q;
   assign pending  = pending_q;

endmodule
